key_bounce_gen: RTL
===================

Name: key_bounce_gen

Overview:
Emulates a mechanical push-button. It produces a bouncy, active-low key level on its output, which drives the keyIn input of the team's key debouncer. It is used for on-board self-test and loopback benches of the debouncing path. On command it drives a pseudo-random toggle burst and then settles to the requested level, holds it, and reports completion.

Parameters:
BOUNCE_LEN, 16, length of the bounce window in cycles (>=1)
MAX_GAP, 4, maximum cycles between toggles; power of two, 1..128
SETTLE, 8, cycles the final level is held stable before done (>=5, so a 4-sample debouncer resolves)
SEED, 8'hA5, LFSR reset value; must be nonzero

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request a key transition; sampled only in IDLE
level  input  1  target key level (0 = pressed, 1 = released)
bounce_en  input  1  1 = generate a bounce burst, 0 = clean transition
keyOut  output  1  emulated key line, idle high; registered
busy  output  1  high while a sequence runs; registered
done  output  1  one-cycle pulse when a sequence completes; registered

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-low.
- Reset (rst=0, asynchronous):
  - Outputs: keyOut=1, busy=0, done=0.
  - Internal: state=IDLE, lfsr=SEED, all counters 0.
  - Reset mid-sequence aborts immediately. The next run replays the identical sequence.
- LFSR:
  - 8-bit Fibonacci; shift left; bit0 <= l[7]^l[5]^l[4]^l[3].
  - Advances once per cycle, in BOUNCE only.
- Gap value: gap = (lfsr mod MAX_GAP) + 1, always in 1..MAX_GAP.
- FSM states: IDLE, BOUNCE, SETTLE. All outputs are registered. busy=1 in BOUNCE and SETTLE.
- IDLE:
  - done=0 except the completion pulse.
  - start=1 with bounce_en=1 -> latch target=level; keyOut<=target; bounce_cnt<=BOUNCE_LEN-1; gap_cnt<=gap-1; busy<=1; go to BOUNCE.
  - start=1 with bounce_en=0 -> latch target; keyOut<=target; settle_cnt<=SETTLE-1; busy<=1; go to SETTLE.
  - start with level equal to the current keyOut still runs the full sequence.
- BOUNCE, evaluated each cycle:
  - If bounce_cnt==0: keyOut<=target; settle_cnt<=SETTLE-1; go to SETTLE. Any pending toggle is discarded.
  - Else if gap_cnt==0: keyOut<=~keyOut; gap_cnt<=gap-1; bounce_cnt decrements.
  - Else: gap_cnt and bounce_cnt decrement.
- SETTLE:
  - keyOut is held at target.
  - When settle_cnt==0: done<=1 for one cycle, busy<=0, go to IDLE.
  - Otherwise settle_cnt decrements.
- Timing, with start sampled at edge 0:
  - keyOut=target after edge 0.
  - bounce_en=1: final keyOut=target from edge BOUNCE_LEN; done=1 and busy=0 at edge BOUNCE_LEN+SETTLE.
  - bounce_en=0: done at edge SETTLE.
- Guarantees:
  - keyOut is constant at target from the end of BOUNCE until the next accepted start.
  - Toggle spacing is never below 1 cycle nor above MAX_GAP cycles.
- Simultaneous events:
  - start while busy is ignored; level and bounce_en changes while busy are ignored.
  - start in the same cycle as done (last SETTLE cycle) is ignored. A new start is accepted from the cycle after done.
- Widths: bounce_cnt is clog2(BOUNCE_LEN) bits, settle_cnt is clog2(SETTLE) bits, gap_cnt is clog2(MAX_GAP) bits (minimum 1). No counter wrap is possible.

Test Plan:
1. Reset: hold rst=0 for 3 cycles, with start toggling -> keyOut=1, busy=0, done=0 throughout; release -> still idle.
2. Clean press: bounce_en=0, level=0, start 1-cycle pulse at edge 0 -> keyOut=0 from edge 0; busy=1 for 8 cycles; done=1 only in the cycle after edge 8; keyOut stays 0.
3. Bouncy press with defaults and SEED=A5 -> keyOut toggle timestamps match the bench LFSR model exactly. All toggle gaps are in 1..4. keyOut=0 from edge 16 and stable. done at edge 24.
4. Busy protection: a start pulse at edges 3 and 20 during a bouncy run -> exactly one done, at edge 24, and no new sequence. A start at edge 25 begins a new run.
5. Mid-run reset: rst=0 at edge 7 of BOUNCE -> keyOut=1 and busy=0 immediately. A repeat of scenario 3 reproduces identical toggle timestamps.
6. Loopback into the 4-sample key debouncer: press (level=0) then release (level=1), each with bounce_en=1 -> debouncer output is 0 before the press done and 1 before the release done.

Source files
------------

// File: rtl/key_bounce_gen.sv
// key_bounce_gen: emulates a mechanical push-button for self-test of the key
// debouncing path. On an accepted start it drives the target level, optionally
// chatters it with LFSR-spaced toggles for BOUNCE_LEN cycles, then holds the
// target for SETTLE cycles and pulses done. keyOut idles high (released).
module key_bounce_gen #(
  parameter int         BOUNCE_LEN = 16,
  parameter int         MAX_GAP    = 4,
  parameter int         SETTLE     = 8,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic level,
  input  logic bounce_en,
  output logic keyOut,
  output logic busy,
  output logic done
);

  localparam int BW = (BOUNCE_LEN > 1) ? $clog2(BOUNCE_LEN) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int GW = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;

  localparam logic [BW-1:0] BOUNCE_LAST = BW'(BOUNCE_LEN - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [7:0]    GAP_MASK    = 8'(MAX_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t state;
  state_t stateNxt;

  logic [7:0]    lfsr;
  logic [BW-1:0] bounceCnt;
  logic [SW-1:0] settleCnt;
  logic [GW-1:0] gapCnt;
  logic          target;

  logic [7:0]    lfsrNxt;
  logic [BW-1:0] bounceNxt;
  logic [SW-1:0] settleNxt;
  logic [GW-1:0] gapNxt;
  logic          targetNxt;
  logic          keyNxt;
  logic          busyNxt;
  logic          doneNxt;

  // 8-bit Fibonacci LFSR step, taps 7,5,4,3, shifting left
  function automatic logic [7:0] lfsrStep(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Gap minus one: lfsr mod MAX_GAP, so the loaded counter spans 1..MAX_GAP cycles
  function automatic logic [GW-1:0] gapLess1(input logic [7:0] l);
    logic [7:0] m;
    m = l & GAP_MASK;
    return m[GW-1:0];
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= stateNxt;
  end

  // Next-state decision
  always_comb begin
    stateNxt = state;
    case (state)
      ST_IDLE: begin
        if (start) stateNxt = bounce_en ? ST_BOUNCE : ST_SETTLE;
      end
      ST_BOUNCE: begin
        if (bounceCnt == '0) stateNxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settleCnt == '0) stateNxt = ST_IDLE;
      end
      default: stateNxt = ST_IDLE;
    endcase
  end

  // Next values for the key line, status flags, counters and LFSR
  always_comb begin
    lfsrNxt   = lfsr;
    bounceNxt = bounceCnt;
    settleNxt = settleCnt;
    gapNxt    = gapCnt;
    targetNxt = target;
    keyNxt    = keyOut;
    busyNxt   = busy;
    doneNxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          targetNxt = level;
          keyNxt    = level;
          busyNxt   = 1'b1;
          if (bounce_en) begin
            bounceNxt = BOUNCE_LAST;
            gapNxt    = gapLess1(lfsr);
          end else begin
            settleNxt = SETTLE_LAST;
          end
        end
      end
      ST_BOUNCE: begin
        lfsrNxt = lfsrStep(lfsr);
        if (bounceCnt == '0) begin
          // window over: snap to target, a toggle due this cycle is dropped
          keyNxt    = target;
          settleNxt = SETTLE_LAST;
        end else begin
          bounceNxt = bounceCnt - BW'(1);
          if (gapCnt == '0) begin
            keyNxt = ~keyOut;
            gapNxt = gapLess1(lfsr);
          end else begin
            gapNxt = gapCnt - GW'(1);
          end
        end
      end
      ST_SETTLE: begin
        keyNxt = target;
        if (settleCnt == '0) begin
          doneNxt = 1'b1;
          busyNxt = 1'b0;
        end else begin
          settleNxt = settleCnt - SW'(1);
        end
      end
      default: begin
        keyNxt  = 1'b1;
        busyNxt = 1'b0;
      end
    endcase
  end

  // Registered outputs and datapath; reset aborts any run and restarts the LFSR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr      <= SEED;
      bounceCnt <= '0;
      settleCnt <= '0;
      gapCnt    <= '0;
      target    <= 1'b1;
      keyOut    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      lfsr      <= lfsrNxt;
      bounceCnt <= bounceNxt;
      settleCnt <= settleNxt;
      gapCnt    <= gapNxt;
      target    <= targetNxt;
      keyOut    <= keyNxt;
      busy      <= busyNxt;
      done      <= doneNxt;
    end
  end

  // The key line must sit at the target for the whole settle phase
  assert property (@(posedge clk) disable iff (!rst)
                   (state == ST_SETTLE) |-> (keyOut == target));

  // busy is a registered image of "not idle"
  assert property (@(posedge clk) disable iff (!rst)
                   busy == (state != ST_IDLE));

endmodule
